// File: rtl/fifo_word_serializer_if.sv
// Signal bundle linking a FIFO read port, the word serializer and the downstream beat consumer.
// The serializer takes the master side; the FIFO and the consumer together take the slave side.
interface fifo_word_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [OUT_WIDTH-1:0]  out_data;
    logic                  out_valid;
    logic                  out_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  out_ready,
        output fifo_rd_en,
        output out_data,
        output out_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output out_ready,
        input  fifo_rd_en,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/fifo_word_serializer.sv
// Pops one FIFO word at a time and streams it out as OUT_WIDTH-bit beats on valid/ready.
// Counts completed words; order of beats within a word is selected by MSB_FIRST.
//
// state | meaning
// IDLE  | waiting for fifo_on with a non-empty FIFO; the pop is issued here
// LOAD  | FIFO read data is valid; captured into the shift register
// SEND  | presenting beats until the last one is accepted
module fifo_word_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int OUT_WIDTH  = 8,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fifo_on,
    fifo_word_serializer_if.master   bus,
    output logic                     busy,
    output logic [CNT_WIDTH-1:0]     words_sent
);
    localparam int BEATS  = DATA_WIDTH / OUT_WIDTH;
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        SEND = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [BEAT_W-1:0]     beat;
    logic                  pop;
    logic                  accept;
    logic                  last_accept;

    assign accept      = (state == SEND) && bus.out_ready;
    assign last_accept = accept && (beat == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The pop term is gated by rst so the FIFO is never read while held in reset.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                pop = fifo_on && !bus.fifo_empty && !rst;
                if (pop) begin
                    state_next = LOAD;
                end
            end
            LOAD: state_next = SEND;
            SEND: begin
                if (last_accept) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // No shift on the final beat, so out_data keeps showing it once the word is done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shift_reg  <= '0;
            beat       <= '0;
            words_sent <= '0;
        end else begin
            if (state == LOAD) begin
                shift_reg <= bus.fifo_dout;
                beat      <= '0;
            end else if (accept && !last_accept) begin
                if (MSB_FIRST) begin
                    shift_reg <= shift_reg << OUT_WIDTH;
                end else begin
                    shift_reg <= shift_reg >> OUT_WIDTH;
                end
                beat <= beat + 1'b1;
            end
            if (last_accept) begin
                words_sent <= words_sent + 1'b1;
            end
        end
    end

    generate
        if (MSB_FIRST) begin : g_msb_first
            assign bus.out_data = shift_reg[DATA_WIDTH-1 -: OUT_WIDTH];
        end else begin : g_lsb_first
            assign bus.out_data = shift_reg[OUT_WIDTH-1:0];
        end
    endgenerate

    assign bus.fifo_rd_en = pop;
    assign bus.out_valid  = (state == SEND);
    assign busy           = (state != IDLE);
endmodule

// File: tb/tb_fifo_word_serializer.sv
// Bench for fifo_word_serializer: an MSB-first instance and an LSB-first instance with a
// narrow word counter, each fed by a queue-backed FIFO and compared against a beat model.
module tb_fifo_word_serializer;
    localparam int DW    = 32;
    localparam int OW    = 8;
    localparam int BEATS = DW / OW;

    typedef struct {
        logic [31:0] word;
        logic [7:0]  b [BEATS];
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a, rst_b, on_a, on_b, busy_a, busy_b;
    logic [15:0] ws_a;
    logic [2:0]  ws_b;

    fifo_word_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus_a ();
    fifo_word_serializer_if #(.DATA_WIDTH(DW), .OUT_WIDTH(OW)) bus_b ();

    fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut_a (
        .clk(clk), .rst(rst_a), .fifo_on(on_a), .bus(bus_a), .busy(busy_a), .words_sent(ws_a));
    fifo_word_serializer #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .MSB_FIRST(1'b0), .CNT_WIDTH(3)) dut_b (
        .clk(clk), .rst(rst_b), .fifo_on(on_b), .bus(bus_b), .busy(busy_b), .words_sent(ws_b));

    int          n_pass = 0, n_total = 0, cyc = 0;
    logic [31:0] fq_a [$];
    logic [31:0] fq_b [$];
    int          pushed_a = 0, popped_a = 0, pushed_b = 0, popped_b = 0;
    logic [7:0]  exp_a [$];
    logic [7:0]  exp_b [$];
    logic [7:0]  got_a [$];
    logic [7:0]  got_b [$];
    int          pop_cyc_a [$];
    int          beat_cyc_a [$];
    int          pops_a = 0, pops_b = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        rand_ready_en = 1'b0, ready_val_a = 1'b0;
    logic [15:0] ws_exp_a = 16'd0;
    vec_t        tbl [5];

    // FIFO models: data appears the cycle after a pop, empty follows the queue fill level.
    assign bus_a.fifo_empty = (pushed_a == popped_a);
    assign bus_b.fifo_empty = (pushed_b == popped_b);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus_a.fifo_rd_en && !bus_a.fifo_empty) begin
            bus_a.fifo_dout <= fq_a[popped_a];
            popped_a        <= popped_a + 1;
        end
        if (bus_b.fifo_rd_en && !bus_b.fifo_empty) begin
            bus_b.fifo_dout <= fq_b[popped_b];
            popped_b        <= popped_b + 1;
        end
    end

    always @(posedge clk) begin
        #2;
        bus_a.out_ready = rand_ready_en ? 1'($urandom_range(0, 1)) : ready_val_a;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, req, $time);
    endtask

    function automatic logic [7:0] mbeat(input logic [31:0] w, input int k, input bit msb);
        logic [31:0] t;
        t = w >> (msb ? OW * (BEATS - 1 - k) : OW * k);
        return t[7:0];
    endfunction

    task automatic push_a(input logic [31:0] w, input bit model);
        fq_a.push_back(w);
        pushed_a++;
        if (model) for (int k = 0; k < BEATS; k++) exp_a.push_back(mbeat(w, k, 1'b1));
    endtask

    task automatic push_b(input logic [31:0] w, input bit model);
        fq_b.push_back(w);
        pushed_b++;
        if (model) for (int k = 0; k < BEATS; k++) exp_b.push_back(mbeat(w, k, 1'b0));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_a(input logic [15:0] target, input int budget, input string nm);
        int n = 0;
        while ((ws_a !== target || busy_a !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_words_sent"}, ws_a, target);
        chk({nm, "_busy"}, busy_a, 0);
    endtask

    task automatic wait_b(input logic [2:0] target, input int budget, input string nm);
        int n = 0;
        while ((ws_b !== target || busy_b !== 1'b0 || pushed_b != popped_b) && n < budget) begin
            tick();
            n++;
        end
        chk({nm, "_words_sent"}, ws_b, target);
        chk({nm, "_busy"}, busy_b, 0);
    endtask

    task automatic check_beats_a(input string nm, input int n);
        chk({nm, "_beat_count"}, got_a.size(), n);
        while (got_a.size() > 0 && exp_a.size() > 0) chk({nm, "_beat"}, got_a.pop_front(), exp_a.pop_front());
        got_a.delete();
    endtask

    task automatic check_beats_b(input string nm, input int n);
        chk({nm, "_beat_count"}, got_b.size(), n);
        while (got_b.size() > 0 && exp_b.size() > 0) chk({nm, "_beat"}, got_b.pop_front(), exp_b.pop_front());
        got_b.delete();
    endtask

    // Monitor: pops, accepted beats, pop legality and backpressure stability.
    always @(negedge clk) begin
        if (bus_a.fifo_rd_en && !bus_a.fifo_empty) begin
            pops_a++;
            pop_cyc_a.push_back(cyc);
        end
        if (bus_a.fifo_rd_en) begin
            chk("a_rd_when_empty", bus_a.fifo_empty, 0);
            chk("a_rd_while_busy", busy_a, 0);
        end
        if (prev_stall) begin
            chk("a_hold_valid", bus_a.out_valid, 1);
            chk("a_hold_data", bus_a.out_data, prev_data);
        end
        prev_stall = bus_a.out_valid && !bus_a.out_ready;
        prev_data  = bus_a.out_data;
        if (bus_a.out_valid && bus_a.out_ready) begin
            got_a.push_back(bus_a.out_data);
            beat_cyc_a.push_back(cyc);
        end
        if (bus_b.fifo_rd_en && !bus_b.fifo_empty) pops_b++;
        if (bus_b.fifo_rd_en) begin
            chk("b_rd_when_empty", bus_b.fifo_empty, 0);
            chk("b_rd_while_busy", busy_b, 0);
        end
        if (bus_b.out_valid && bus_b.out_ready) got_b.push_back(bus_b.out_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, base;

        tbl[0].word = 32'hA5A5_0FF0; tbl[0].b = '{8'hA5, 8'hA5, 8'h0F, 8'hF0};
        tbl[1].word = 32'h8000_0001; tbl[1].b = '{8'h80, 8'h00, 8'h00, 8'h01};
        tbl[2].word = 32'hFFFF_FFFF; tbl[2].b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
        tbl[3].word = 32'h0000_0000; tbl[3].b = '{8'h00, 8'h00, 8'h00, 8'h00};
        tbl[4].word = 32'hDEAD_BEEF; tbl[4].b = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};

        rst_a = 1'b1; rst_b = 1'b1; on_a = 1'b0; on_b = 1'b0;
        bus_b.out_ready = 1'b0;
        push_a(32'h1122_3344, 1'b1);

        // Reset and idle with a non-empty FIFO but fifo_on low
        #95;
        chk("rst_valid", bus_a.out_valid, 0);
        chk("rst_rd_en", bus_a.fifo_rd_en, 0);
        chk("rst_words_sent", ws_a, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_out_data", bus_a.out_data, 0);
        @(posedge clk); #1;
        rst_a = 1'b0; rst_b = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("idle_rd_en", bus_a.fifo_rd_en, 0);
            chk("idle_valid", bus_a.out_valid, 0);
            chk("idle_words_sent", ws_a, 0);
            chk("idle_busy", busy_a, 0);
            tick();
        end
        chk("idle_pops", pops_a, 0);

        // Single word: pop in cycle c0, beats in c0+2..c0+5
        pop_cyc_a.delete(); beat_cyc_a.delete(); got_a.delete();
        ready_val_a = 1'b1;
        on_a = 1'b1;
        c0 = cyc;
        wait_a(16'd1, 30, "single");
        ws_exp_a = 16'd1;
        chk("single_pops", pops_a, 1);
        chk("single_pop_count", pop_cyc_a.size(), 1);
        if (pop_cyc_a.size() > 0) chk("single_pop_cyc", pop_cyc_a[0], c0);
        chk("single_beat_cyc_count", beat_cyc_a.size(), 4);
        for (int k = 0; k < beat_cyc_a.size() && k < BEATS; k++) chk("single_beat_cyc", beat_cyc_a[k], c0 + 2 + k);
        check_beats_a("single", 4);

        // Table-driven words with hand-written expected beats
        for (int i = 0; i < 5; i++) begin
            got_a.delete();
            push_a(tbl[i].word, 1'b0);
            ws_exp_a++;
            wait_a(ws_exp_a, 30, "tbl");
            chk("tbl_count", got_a.size(), BEATS);
            for (int k = 0; k < got_a.size() && k < BEATS; k++) chk("tbl_beat", got_a[k], tbl[i].b[k]);
            got_a.delete();
        end

        // Stream drain: six words, one pop every BEATS+2 cycles
        base = pops_a;
        pop_cyc_a.delete();
        for (int i = 0; i < 6; i++) push_a(32'(i), 1'b1);
        ws_exp_a += 16'd6;
        wait_a(ws_exp_a, 100, "drain");
        repeat (10) tick();
        chk("drain_pops", pops_a - base, 6);
        chk("drain_pop_count", pop_cyc_a.size(), 6);
        for (int i = 1; i < pop_cyc_a.size(); i++) chk("drain_pop_spacing", pop_cyc_a[i] - pop_cyc_a[i-1], BEATS + 2);
        check_beats_a("drain", 24);

        // Backpressure: out_ready low for exactly 3 cycles while 0xB2 is presented
        push_a(32'hA1B2_C3D4, 1'b1);
        ws_exp_a++;
        tick(); tick(); tick();
        ready_val_a = 1'b0;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk);
            chk("bp_valid", bus_a.out_valid, 1);
            chk("bp_data", bus_a.out_data, 8'hB2);
            if (s == 2) ready_val_a = 1'b1;
            tick();
        end
        wait_a(ws_exp_a, 30, "bp");
        check_beats_a("bp", 4);

        // fifo_on dropped during beat 1: word completes, no second pop
        base = pops_a;
        push_a(32'h0102_0304, 1'b1);
        push_a(32'h0506_0708, 1'b1);
        tick(); tick(); tick();
        on_a = 1'b0;
        ws_exp_a++;
        wait_a(ws_exp_a, 30, "edrop");
        repeat (10) tick();
        chk("edrop_pops", pops_a - base, 1);
        chk("edrop_busy", busy_a, 0);
        chk("edrop_left_in_fifo", pushed_a - popped_a, 1);
        check_beats_a("edrop", 4);

        // Random words and random out_ready against the beat model
        base = pops_a;
        rand_ready_en = 1'b1;
        on_a = 1'b1;
        for (int i = 0; i < 30; i++) begin
            push_a($urandom, 1'b1);
            repeat ($urandom_range(0, 10)) tick();
        end
        ws_exp_a += 16'd31;
        wait_a(ws_exp_a, 4000, "rand");
        chk("rand_pops", pops_a - base, 31);
        check_beats_a("rand", 124);
        rand_ready_en = 1'b0;

        // LSB-first instance
        on_b = 1'b1;
        bus_b.out_ready = 1'b1;
        push_b(32'h1122_3344, 1'b1);
        wait_b(3'd1, 30, "lsb");
        check_beats_b("lsb", 4);

        // Reset after two beats of 0xDEADBEEF
        push_b(32'hDEAD_BEEF, 1'b0);
        push_b(32'hCAFE_F00D, 1'b1);
        tick(); tick(); tick(); tick();
        rst_b = 1'b1;
        #1;
        chk("mid_rst_valid", bus_b.out_valid, 0);
        chk("mid_rst_words_sent", ws_b, 0);
        chk("mid_rst_busy", busy_b, 0);
        chk("mid_rst_rd_en", bus_b.fifo_rd_en, 0);
        chk("mid_rst_partial_count", got_b.size(), 2);
        if (got_b.size() >= 2) begin
            chk("mid_rst_beat0", got_b[0], 8'hEF);
            chk("mid_rst_beat1", got_b[1], 8'hBE);
        end
        got_b.delete();
        tick();
        chk("in_rst_rd_en", bus_b.fifo_rd_en, 0);
        rst_b = 1'b0;

        // Next word restarts at beat 0; counter wraps (9 words on a 3-bit counter)
        for (int i = 0; i < 8; i++) push_b($urandom, 1'b1);
        wait_b(3'd1, 400, "wrap");
        chk("wrap_pops", pops_b, 11);
        check_beats_b("wrap", 36);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
